// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - in-order retire end of the ROB with precise-exception flush and mispredict squash
//
// Holds per-entry valid/done/exception state plus destination fields. Dispatch writes the entry at
// dispatch_idx, writebacks mark entries done by ROB index, and the head entry retires when done.
// A faulting head enters FLUSH (one exc_flush pulse, all entries dropped, head back to 0) then DRAIN.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   dispatch_*                    new entry written at dispatch_idx (tail from rob_controller)
//   wb_valid/wb_idx/wb_exception  completion of an in-flight entry
//   branch_mispredict/recovery_idx squash of every entry younger than recovery_idx
//   commit_*                      head retirement (commit_en qualifies the fields)
//   free_en/free_prd              previous physical mapping released at retire
//   exc_flush/exc_idx             one-cycle flush pulse carrying the faulting ROB index
//   rob_empty                     no valid entries
//   retired_count                 only with ROB_COMMIT_STATS_EN: saturating retire counter
//
// Optional feature macro: ROB_COMMIT_STATS_EN
module rob_commit_unit #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_en,
    input  logic [IDX_W-1:0]  dispatch_idx,
    input  logic              dispatch_rd_we,
    input  logic [4:0]        dispatch_rd,
    input  logic [PREG_W-1:0] dispatch_prd,
    input  logic [PREG_W-1:0] dispatch_old_prd,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic              wb_exception,
    input  logic              branch_mispredict,
    input  logic [IDX_W-1:0]  recovery_idx,
    output logic              commit_en,
    output logic [IDX_W-1:0]  commit_idx,
    output logic              commit_rd_we,
    output logic [4:0]        commit_rd,
    output logic [PREG_W-1:0] commit_prd,
    output logic              free_en,
    output logic [PREG_W-1:0] free_prd,
    output logic              exc_flush,
    output logic [IDX_W-1:0]  exc_idx,
    output logic              rob_empty
`ifdef ROB_COMMIT_STATS_EN
    ,
    output logic [31:0]       retired_count
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    done_q, done_d;
    logic [DEPTH-1:0]    exc_q, exc_d;
    logic [DEPTH-1:0]    rd_we_q, rd_we_d;
    logic [4:0]          rd_q [DEPTH];
    logic [4:0]          rd_d [DEPTH];
    logic [PREG_W-1:0]   prd_q [DEPTH];
    logic [PREG_W-1:0]   prd_d [DEPTH];
    logic [PREG_W-1:0]   old_q [DEPTH];
    logic [PREG_W-1:0]   old_d [DEPTH];
    logic [IDX_W-1:0]    head_q, head_d;
    logic [IDX_W-1:0]    age [DEPTH];
    logic [IDX_W-1:0]    rec_age;
    logic                head_ready;

    assign head_ready = valid_q[head_q] & done_q[head_q];
    assign rob_empty  = ~|valid_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        done_d       = done_q;
        exc_d        = exc_q;
        rd_we_d      = rd_we_q;
        rd_d         = rd_q;
        prd_d        = prd_q;
        old_d        = old_q;
        head_d       = head_q;
        commit_en    = 1'b0;
        commit_idx   = '0;
        commit_rd_we = 1'b0;
        commit_rd    = '0;
        commit_prd   = '0;
        free_en      = 1'b0;
        free_prd     = '0;
        exc_flush    = 1'b0;
        exc_idx      = '0;
        // Age relative to head: squash compares distances so the ring wrap is handled naturally.
        rec_age = recovery_idx - head_q;
        for (int i = 0; i < DEPTH; i++) begin
            age[i] = IDX_W'(i) - head_q;
        end

        case (state_q)
            ST_RUN: begin
                // Gated by reset so no retire/free pulse escapes while reset is asserted.
                if (!reset && head_ready && !exc_q[head_q]) begin
                    commit_en    = 1'b1;
                    commit_idx   = head_q;
                    commit_rd_we = rd_we_q[head_q];
                    commit_rd    = rd_q[head_q];
                    commit_prd   = prd_q[head_q];
                    free_en      = rd_we_q[head_q];
                    free_prd     = old_q[head_q];
                end
                if (wb_valid && valid_q[wb_idx]) begin
                    done_d[wb_idx] = 1'b1;
                    exc_d[wb_idx]  = wb_exception;
                end
                if (branch_mispredict) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (age[i] > rec_age) begin
                            valid_d[i] = 1'b0;
                        end
                    end
                end else if (dispatch_en) begin
                    valid_d[dispatch_idx] = 1'b1;
                    done_d[dispatch_idx]  = 1'b0;
                    exc_d[dispatch_idx]   = 1'b0;
                    rd_we_d[dispatch_idx] = dispatch_rd_we;
                    rd_d[dispatch_idx]    = dispatch_rd;
                    prd_d[dispatch_idx]   = dispatch_prd;
                    old_d[dispatch_idx]   = dispatch_old_prd;
                end
                if (commit_en) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + 1'b1;
                end
                if (head_ready && exc_q[head_q]) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                exc_flush = !reset;
                exc_idx   = head_q;
                valid_d   = '0;
                head_d    = '0;
                state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
            head_q  <= head_d;
        end
        rd_we_q <= rd_we_d;
        rd_q    <= rd_d;
        prd_q   <= prd_d;
        old_q   <= old_d;
    end

`ifdef ROB_COMMIT_STATS_EN
    logic [31:0] retired_count_q, retired_count_d;

    always_comb begin
        retired_count_d = retired_count_q;
        if (commit_en && retired_count_q != 32'hFFFF_FFFF) begin
            retired_count_d = retired_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign retired_count = retired_count_q;
`endif

    // rob_controller never dispatches into an occupied slot.
    dispatch_to_valid_entry: assert property (@(posedge clk) disable iff (reset)
        !(state_q == ST_RUN && dispatch_en && !branch_mispredict && valid_q[dispatch_idx]))
        else $error("dispatch into occupied ROB entry %0d", dispatch_idx);

endmodule
